// File: rtl/div_seq.sv
// Sequential restoring divider: WIDTH clocks from accepted start to a one-cycle done pulse.
// start is ignored while busy; divide-by-zero completes in one clock with all-ones quotient.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_reg, q_nxt;
   logic [WIDTH-1:0] b_reg, b_nxt;
   logic [WIDTH-1:0] r_reg, r_nxt;
   logic [CW-1:0]    count, count_nxt;
   logic [WIDTH-1:0] quot_nxt, rem_nxt;
   logic             dz_nxt;
   logic             busy_nxt, done_nxt;

   logic [WIDTH:0]   n_val;
   logic [WIDTH:0]   s_val;
   logic             s_neg;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] step_r;
   logic             last_step;

   // Partial remainder is compared at WIDTH+1 bits so an MSB-set divisor never loses a bit.
   assign n_val     = {r_reg, q_reg[WIDTH-1]};
   assign s_val     = n_val - {1'b0, b_reg};
   assign s_neg     = s_val[WIDTH];
   assign step_q    = {q_reg[WIDTH-2:0], ~s_neg};
   assign step_r    = s_neg ? n_val[WIDTH-1:0] : s_val[WIDTH-1:0];
   assign last_step = (count == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      q_nxt     = q_reg;
      b_nxt     = b_reg;
      r_nxt     = r_reg;
      count_nxt = count;
      quot_nxt  = quotient;
      rem_nxt   = remainder;
      dz_nxt    = div_zero;

      case (state)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (start) begin
               if (divisor == '0) begin
                  state_nxt = DONE;
                  quot_nxt  = '1;
                  rem_nxt   = dividend;
                  dz_nxt    = 1'b1;
               end else begin
                  state_nxt = RUN;
                  q_nxt     = dividend;
                  b_nxt     = divisor;
                  r_nxt     = '0;
                  count_nxt = '0;
                  dz_nxt    = 1'b0;
               end
            end
         end
         RUN: begin
            q_nxt     = step_q;
            r_nxt     = step_r;
            count_nxt = count + CW'(1);
            if (last_step) begin
               state_nxt = DONE;
               quot_nxt  = step_q;
               rem_nxt   = step_r;
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         q_reg     <= '0;
         b_reg     <= '0;
         r_reg     <= '0;
         count     <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         q_reg     <= q_nxt;
         b_reg     <= b_nxt;
         r_reg     <= r_nxt;
         count     <= count_nxt;
         quotient  <= quot_nxt;
         remainder <= rem_nxt;
         div_zero  <= dz_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: scoreboard of expected quotient/remainder/div_zero, latency and pulse-width checks.
module tb_div_seq;

   localparam int W = 32;

   logic          clock;
   logic          reset_n;
   logic          start;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_zero;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   div_seq #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Called just after a negedge; returns at the negedge following the accept edge.
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
      end else begin
         e.q  = a / b;
         e.r  = a % b;
         e.dz = 1'b0;
      end
      sb.push_back(e);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_result(input int lat, input string name);
      int   cyc = 0;
      bit   busy_bad = 0;
      exp_t e;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy !== 1'b1) busy_bad = 1;
         @(negedge clock);
         cyc++;
      end
      checks++;
      if (cyc != lat) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, lat);
      end
      checks++;
      if (busy_bad || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: busy profile wrong (busy_bad=%0d, busy at done=%b)", name, busy_bad, busy);
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard: empty at done, got q=%0h r=%0h", name, quotient, remainder);
      end else begin
         e = sb.pop_front();
         checks++;
         if (quotient !== e.q) begin
            errors++;
            $display("FAIL %s quotient: got %0h expected %0h", name, quotient, e.q);
         end
         checks++;
         if (remainder !== e.r) begin
            errors++;
            $display("FAIL %s remainder: got %0h expected %0h", name, remainder, e.r);
         end
         checks++;
         if (div_zero !== e.dz) begin
            errors++;
            $display("FAIL %s div_zero: got %b expected %b", name, div_zero, e.dz);
         end
      end
   endtask

   task automatic check_done_drop(input string name);
      @(negedge clock);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s done_width: done=%b one cycle later, expected 0", name, done);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clock);
      checks++;
      if ({busy, done, div_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b dz=%b q=%0h r=%0h, expected all 0",
                  busy, done, div_zero, quotient, remainder);
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic();
      drive_start(32'd100, 32'd7);
      wait_result(W, "div_100_7");
      check_done_drop("div_100_7");
      drive_start(32'hFFFF_FFFF, 32'h8000_0001);
      wait_result(W, "div_msb_divisor");
      check_done_drop("div_msb_divisor");
   endtask

   task automatic test_div_zero();
      drive_start(32'h1234, 32'h0);
      wait_result(0, "div_zero");
      check_done_drop("div_zero");
   endtask

   task automatic test_back_to_back();
      drive_start(32'd50, 32'd3);
      repeat (9) @(negedge clock);
      dividend = 32'd9;
      divisor  = 32'd9;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL ignored_start busy: got %b expected 1", busy);
      end
      wait_result(W - 10, "div_50_3");
      drive_start(32'd9, 32'd9);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back accept: done=%b busy=%b, expected done=0 busy=1", done, busy);
      end
      wait_result(W, "div_9_9");
      check_done_drop("div_9_9");
   endtask

   task automatic test_reset_mid_run();
      drive_start(32'd1000, 32'd10);
      void'(sb.pop_back());
      repeat (14) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
         errors++;
         $display("FAIL async_reset: busy=%b done=%b dz=%b q=%0h r=%0h, expected all 0",
                  busy, done, div_zero, quotient, remainder);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      drive_start(32'd1000, 32'd10);
      wait_result(W, "div_1000_10");
      check_done_drop("div_1000_10");
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = 32'd1;
         2:       v = '1;
         3:       v = W'($urandom_range(0, 255));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int i = 0; i < 250; i++) begin
         a = pick_operand();
         b = pick_operand();
         drive_start(a, b);
         wait_result((b == '0) ? 0 : W, "random");
         check_done_drop("random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
